// File: rtl/apb_master_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// apb_master_arbiter_pkg
//   Shared definitions for the APB master arbiter: FSM state encoding and
//   small elaboration-time helpers used to size and step internal registers.
//   No ports (package).
// ----------------------------------------------------------------------------
package apb_master_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   // Width of the wait-state counter: must hold the value TIMEOUT itself.
   function automatic int tmo_w(input int tmo);
      return $clog2(tmo + 1);
   endfunction

   // Rotating-priority successor of a requester index.
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/apb_master_arbiter_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Combinational rotating-priority pick. The search starts at i_ptr and
//   wraps modulo NREQ; the first asserted request wins.
// Ports
//   i_req  in  NREQ  request vector
//   i_ptr  in  PW    index where the priority search starts
//   o_gnt  out NREQ  one-hot grant (all zero when no request)
//   o_idx  out PW    index of the granted requester
//   o_any  out 1     at least one request is asserted
// ----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int PW   = 2
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [PW-1:0]   i_ptr,
   output logic [NREQ-1:0] o_gnt,
   output logic [PW-1:0]   o_idx,
   output logic            o_any
);

   always_comb begin
      int j;
      j     = 0;
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         j = int'(i_ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!o_any && i_req[j[PW-1:0]]) begin
            o_any             = 1'b1;
            o_gnt[j[PW-1:0]]  = 1'b1;
            o_idx             = PW'(j);
         end
      end
   end

endmodule

// File: rtl/apb_master_arbiter.sv
// ----------------------------------------------------------------------------
// apb_master_arbiter
//   Shares one APB master port between NREQ requesters. Round-robin grant in
//   IDLE, then a two-phase APB transfer (SETUP, ACCESS). Wait states are
//   honoured; after TIMEOUT ACCESS cycles with pready low the transfer is
//   aborted with an error.
// Ports
//   pclk, reset_n (sync, active-low), enable (clock enable)
//   req/req_write/req_addr/req_wdata : per-requester command (packed buses)
//   done (one-hot strobe), rsp_rdata, rsp_err : response, valid while done!=0
//   paddr/pwrite/psel/penable/pwdata : APB request outputs
//   prdata/pready/pslverr            : APB response inputs
// ----------------------------------------------------------------------------
module apb_master_arbiter
   import apb_master_arbiter_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int AW      = 16,
   parameter int TIMEOUT = 15
) (
   input  logic              pclk,
   input  logic              reset_n,
   input  logic              enable,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ-1:0]   req_write,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*32-1:0] req_wdata,
   output logic [NREQ-1:0]   done,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic [AW-1:0]     paddr,
   output logic              pwrite,
   output logic              psel,
   output logic              penable,
   output logic [31:0]       pwdata,
   input  logic [31:0]       prdata,
   input  logic              pready,
   input  logic              pslverr
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = tmo_w(TIMEOUT);

   state_t          r_state;
   state_t          w_next;
   logic [PW-1:0]   r_ptr;
   logic [PW-1:0]   r_win;
   logic [CW-1:0]   r_cnt;
   logic [AW-1:0]   r_paddr;
   logic [31:0]     r_pwdata;
   logic            r_pwrite;

   logic [NREQ-1:0] w_gnt;
   logic [PW-1:0]   w_gnt_idx;
   logic            w_any;
   logic [AW-1:0]   w_addr;
   logic [31:0]     w_wdata;
   logic            w_write;
   logic            w_tmo;
   logic            w_fin;

   rr_arbiter #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_rr (
      .i_req (req),
      .i_ptr (r_ptr),
      .o_gnt (w_gnt),
      .o_idx (w_gnt_idx),
      .o_any (w_any)
   );

   // One-hot AND-OR capture mux for the winner's command.
   always_comb begin
      w_addr  = '0;
      w_wdata = '0;
      w_write = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_gnt[i]) begin
            w_addr  = w_addr  | req_addr[i*AW +: AW];
            w_wdata = w_wdata | req_wdata[i*32 +: 32];
            w_write = w_write | req_write[i];
         end
      end
   end

   assign w_tmo = (r_cnt == CW'(TIMEOUT));
   // Completion is suppressed while held (enable low) or in reset so that a
   // frozen or aborted ACCESS never produces a duplicate or stray strobe.
   assign w_fin = reset_n && enable && (r_state == ST_ACCESS) && (pready || w_tmo);

   // State register
   always_ff @(posedge pclk) begin
      if (!reset_n)    r_state <= ST_IDLE;
      else if (enable) r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:   if (w_any) w_next = ST_SETUP;
         ST_SETUP:  w_next = ST_ACCESS;
         ST_ACCESS: if (pready || w_tmo) w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   // Pointer, capture registers and wait-state counter
   always_ff @(posedge pclk) begin
      if (!reset_n) begin
         r_ptr    <= '0;
         r_win    <= '0;
         r_cnt    <= '0;
         r_paddr  <= '0;
         r_pwdata <= '0;
         r_pwrite <= 1'b0;
      end else if (enable) begin
         if (r_state == ST_IDLE && w_any) begin
            r_paddr  <= w_addr;
            r_pwdata <= w_wdata;
            r_pwrite <= w_write;
            r_win    <= w_gnt_idx;
            r_ptr    <= PW'(rr_next(int'(w_gnt_idx), NREQ));
            r_cnt    <= '0;
         end else if (r_state == ST_ACCESS && !pready && !w_tmo) begin
            // Saturates at TIMEOUT; the FSM leaves ACCESS on that value.
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   // Output logic
   always_comb begin
      psel      = 1'b0;
      penable   = 1'b0;
      done      = '0;
      rsp_rdata = '0;
      rsp_err   = 1'b0;
      case (r_state)
         ST_SETUP:  psel = 1'b1;
         ST_ACCESS: begin
            psel    = 1'b1;
            penable = 1'b1;
         end
         default: ;
      endcase
      if (w_fin) begin
         done[r_win] = 1'b1;
         rsp_err     = pready ? pslverr : 1'b1;
         rsp_rdata   = pready ? prdata  : 32'h0;
      end
   end

   assign paddr  = r_paddr;
   assign pwdata = r_pwdata;
   assign pwrite = r_pwrite;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// ----------------------------------------------------------------------------
// tb_apb_master_arbiter
//   Self-checking bench: directed per-cycle vector table, hand sequences for
//   contention / timeout / reset mid-transfer, then randomized traffic against
//   a transaction-level reference model.
// ----------------------------------------------------------------------------
module tb_apb_master_arbiter;

   localparam int NREQ    = 4;
   localparam int AW      = 16;
   localparam int TIMEOUT = 15;

   logic                pclk = 1'b0;
   logic                reset_n;
   logic                enable;
   logic [NREQ-1:0]     req;
   logic [NREQ-1:0]     req_write;
   logic [NREQ*AW-1:0]  req_addr;
   logic [NREQ*32-1:0]  req_wdata;
   logic [NREQ-1:0]     done;
   logic [31:0]         rsp_rdata;
   logic                rsp_err;
   logic [AW-1:0]       paddr;
   logic                pwrite;
   logic                psel;
   logic                penable;
   logic [31:0]         pwdata;
   logic [31:0]         prdata;
   logic                pready;
   logic                pslverr;

   apb_master_arbiter #(
      .NREQ    (NREQ),
      .AW      (AW),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .pclk      (pclk),
      .reset_n   (reset_n),
      .enable    (enable),
      .req       (req),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .done      (done),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .paddr     (paddr),
      .pwrite    (pwrite),
      .psel      (psel),
      .penable   (penable),
      .pwdata    (pwdata),
      .prdata    (prdata),
      .pready    (pready),
      .pslverr   (pslverr)
   );

   always #5 pclk = ~pclk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h required 0x%0h at %0t", nm, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic set_req(input int i, input logic w, input logic [15:0] a, input logic [31:0] d);
      req_write[i]          = w;
      req_addr[i*AW +: AW]  = a;
      req_wdata[i*32 +: 32] = d;
   endtask

   typedef struct {
      logic        rst_n;
      logic [3:0]  req;
      logic        pready;
      logic        pslverr;
      logic [31:0] prdata;
      logic        e_psel;
      logic        e_pen;
      logic [3:0]  e_done;
      logic        e_err;
      logic [31:0] e_rdata;
      logic [15:0] e_paddr;
      logic        e_pwrite;
   } vec_t;

   vec_t tbl[$];

   task automatic add_vec(input logic rst_n, input logic [3:0] rq, input logic rdy,
                          input logic serr, input logic [31:0] rd, input logic e_psel,
                          input logic e_pen, input logic [3:0] e_done, input logic e_err,
                          input logic [31:0] e_rdata, input logic [15:0] e_paddr,
                          input logic e_pwrite);
      vec_t v;
      v.rst_n = rst_n; v.req = rq; v.pready = rdy; v.pslverr = serr; v.prdata = rd;
      v.e_psel = e_psel; v.e_pen = e_pen; v.e_done = e_done; v.e_err = e_err;
      v.e_rdata = e_rdata; v.e_paddr = e_paddr; v.e_pwrite = e_pwrite;
      tbl.push_back(v);
   endtask

   // Random-phase state
   bit          pend [NREQ];
   logic [15:0] ra   [NREQ];
   logic [31:0] rw   [NREQ];
   logic        rwr  [NREQ];

   initial begin
      int          order[$];
      int          dcyc[$];
      logic [3:0]  hold;
      int          dc;
      // reference model state
      bit          m_act;
      int          m_ph;
      int          m_own;
      int          m_ptr;
      logic [15:0] m_addr;
      logic [31:0] m_wd;
      logic        m_wr;
      int          stall;
      bit          fin;
      logic [3:0]  e_done;

      reset_n = 1'b0; enable = 1'b1; req = '0; req_write = '0;
      req_addr = '0; req_wdata = '0; prdata = '0; pready = 1'b1; pslverr = 1'b0;
      set_req(0, 1'b1, 16'h0004, 32'h0000_0001);
      set_req(1, 1'b1, 16'h0010, 32'hDEAD_0001);
      set_req(2, 1'b0, 16'h0008, 32'h0000_0000);
      set_req(3, 1'b1, 16'h0020, 32'h0000_0033);

      // rst req rdy err prdata        | psel pen done  err rdata          paddr    pwr
      add_vec(1'b1, 4'b0000, 1'b1, 1'b0, 32'h0,          1'b0, 1'b0, 4'b0000, 1'b0, 32'h0,          16'h0000, 1'b0);
      add_vec(1'b1, 4'b0001, 1'b1, 1'b0, 32'h0,          1'b0, 1'b0, 4'b0000, 1'b0, 32'h0,          16'h0000, 1'b0);
      add_vec(1'b1, 4'b0001, 1'b1, 1'b0, 32'h0,          1'b1, 1'b0, 4'b0000, 1'b0, 32'h0,          16'h0004, 1'b1);
      add_vec(1'b1, 4'b0001, 1'b1, 1'b0, 32'h0,          1'b1, 1'b1, 4'b0001, 1'b0, 32'h0,          16'h0004, 1'b1);
      add_vec(1'b1, 4'b0000, 1'b1, 1'b0, 32'h0,          1'b0, 1'b0, 4'b0000, 1'b0, 32'h0,          16'h0000, 1'b0);
      add_vec(1'b1, 4'b0100, 1'b1, 1'b0, 32'h0,          1'b0, 1'b0, 4'b0000, 1'b0, 32'h0,          16'h0000, 1'b0);
      add_vec(1'b1, 4'b0100, 1'b1, 1'b0, 32'h0,          1'b1, 1'b0, 4'b0000, 1'b0, 32'h0,          16'h0008, 1'b0);
      add_vec(1'b1, 4'b0100, 1'b0, 1'b0, 32'h0,          1'b1, 1'b1, 4'b0000, 1'b0, 32'h0,          16'h0008, 1'b0);
      add_vec(1'b1, 4'b0100, 1'b0, 1'b0, 32'h0,          1'b1, 1'b1, 4'b0000, 1'b0, 32'h0,          16'h0008, 1'b0);
      add_vec(1'b1, 4'b0100, 1'b0, 1'b0, 32'h0,          1'b1, 1'b1, 4'b0000, 1'b0, 32'h0,          16'h0008, 1'b0);
      add_vec(1'b1, 4'b0100, 1'b1, 1'b0, 32'hA5A5_0001,  1'b1, 1'b1, 4'b0100, 1'b0, 32'hA5A5_0001,  16'h0008, 1'b0);
      add_vec(1'b1, 4'b0000, 1'b1, 1'b0, 32'h0,          1'b0, 1'b0, 4'b0000, 1'b0, 32'h0,          16'h0000, 1'b0);
      add_vec(1'b1, 4'b0010, 1'b1, 1'b0, 32'h0,          1'b0, 1'b0, 4'b0000, 1'b0, 32'h0,          16'h0000, 1'b0);
      add_vec(1'b1, 4'b0010, 1'b1, 1'b0, 32'h0,          1'b1, 1'b0, 4'b0000, 1'b0, 32'h0,          16'h0010, 1'b1);
      add_vec(1'b1, 4'b0010, 1'b1, 1'b1, 32'h0000_1234,  1'b1, 1'b1, 4'b0010, 1'b1, 32'h0000_1234,  16'h0010, 1'b1);
      add_vec(1'b1, 4'b0000, 1'b1, 1'b0, 32'h0,          1'b0, 1'b0, 4'b0000, 1'b0, 32'h0,          16'h0000, 1'b0);
      add_vec(1'b1, 4'b1000, 1'b1, 1'b0, 32'h0,          1'b0, 1'b0, 4'b0000, 1'b0, 32'h0,          16'h0000, 1'b0);
      add_vec(1'b1, 4'b1000, 1'b1, 1'b0, 32'h0,          1'b1, 1'b0, 4'b0000, 1'b0, 32'h0,          16'h0020, 1'b1);
      add_vec(1'b1, 4'b1000, 1'b1, 1'b0, 32'h0,          1'b1, 1'b1, 4'b1000, 1'b0, 32'h0,          16'h0020, 1'b1);
      add_vec(1'b1, 4'b0000, 1'b1, 1'b0, 32'h0,          1'b0, 1'b0, 4'b0000, 1'b0, 32'h0,          16'h0000, 1'b0);

      // Reset state
      tick(); tick();
      #2;
      chk("reset psel",    64'(psel),    64'd0);
      chk("reset penable", 64'(penable), 64'd0);
      chk("reset done",    64'(done),    64'd0);
      chk("reset paddr",   64'(paddr),   64'd0);
      chk("reset pwdata",  64'(pwdata),  64'd0);
      chk("reset pwrite",  64'(pwrite),  64'd0);
      tick();

      // Directed vector table
      foreach (tbl[k]) begin
         reset_n = tbl[k].rst_n; req = tbl[k].req; pready = tbl[k].pready;
         pslverr = tbl[k].pslverr; prdata = tbl[k].prdata;
         #2;
         chk($sformatf("tbl%0d psel", k),    64'(psel),    64'(tbl[k].e_psel));
         chk($sformatf("tbl%0d penable", k), 64'(penable), 64'(tbl[k].e_pen));
         chk($sformatf("tbl%0d done", k),    64'(done),    64'(tbl[k].e_done));
         if (tbl[k].e_psel) begin
            chk($sformatf("tbl%0d paddr", k),  64'(paddr),  64'(tbl[k].e_paddr));
            chk($sformatf("tbl%0d pwrite", k), 64'(pwrite), 64'(tbl[k].e_pwrite));
         end
         if (tbl[k].e_done != 4'b0000) begin
            chk($sformatf("tbl%0d rsp_err", k),   64'(rsp_err),   64'(tbl[k].e_err));
            chk($sformatf("tbl%0d rsp_rdata", k), 64'(rsp_rdata), 64'(tbl[k].e_rdata));
         end
         tick();
      end

      // Contention: all four request, each drops on its own done
      hold = 4'b1111; pready = 1'b1; pslverr = 1'b0; prdata = '0;
      for (int c = 0; c < 20; c++) begin
         req = hold;
         #2;
         for (int i = 0; i < NREQ; i++) begin
            if (done[i]) begin
               order.push_back(i);
               dcyc.push_back(c);
               hold[i] = 1'b0;
            end
         end
         tick();
      end
      chk("contention count", 64'(order.size()), 64'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < order.size()) begin
            chk($sformatf("contention order%0d", i), 64'(order[i]), 64'(i));
            if (i == 0) chk("contention first done", 64'(dcyc[0]), 64'd2);
            else        chk($sformatf("contention gap%0d", i), 64'(dcyc[i] - dcyc[i-1]), 64'd3);
         end
      end

      // Timeout: pready stuck low
      req = 4'b0010; pready = 1'b0; prdata = 32'hFFFF_FFFF; dc = -1;
      for (int c = 0; c < 40; c++) begin
         req = (dc < 0) ? 4'b0010 : 4'b0000;
         #2;
         if (c == 10) chk("timeout penable wait", 64'(penable), 64'd1);
         if (dc < 0 && done != 4'b0000) begin
            dc = c;
            chk("timeout done",  64'(done),      64'd2);
            chk("timeout err",   64'(rsp_err),   64'd1);
            chk("timeout rdata", 64'(rsp_rdata), 64'd0);
         end else if (dc >= 0 && c == dc + 1) begin
            chk("timeout psel after", 64'(psel), 64'd0);
         end
         tick();
      end
      chk("timeout done cycle", 64'(dc), 64'(TIMEOUT + 2));

      // Reset mid-ACCESS: requester 2 wins, reset drops it, 0 wins afterward
      req = 4'b0101; pready = 1'b0; prdata = 32'h0;
      tick(); tick();                    // IDLE (grant 2), SETUP
      #2; chk("rst-mid paddr", 64'(paddr), 64'h0008);
      tick();                            // ACCESS, waiting
      reset_n = 1'b0; pready = 1'b1;
      #2; chk("rst-mid done in reset", 64'(done), 64'd0);
      tick();
      reset_n = 1'b1; pready = 1'b0;
      #2;
      chk("rst-mid psel",    64'(psel),    64'd0);
      chk("rst-mid penable", 64'(penable), 64'd0);
      chk("rst-mid done",    64'(done),    64'd0);
      tick();
      #2;
      chk("rst-mid regrant psel",  64'(psel),  64'd1);
      chk("rst-mid regrant paddr", 64'(paddr), 64'h0004);
      tick();
      pready = 1'b1;
      #2; chk("rst-mid regrant done", 64'(done), 64'd1);
      tick();
      req = 4'b0000;
      tick(); tick(); tick();

      // Randomized traffic against a transaction-level model
      reset_n = 1'b0; req = '0;
      tick();
      reset_n = 1'b1;
      m_act = 1'b0; m_ph = 0; m_own = 0; m_ptr = 0;
      m_addr = '0; m_wd = '0; m_wr = 1'b0; stall = 0;
      for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && $urandom_range(3) == 0) begin
               pend[i] = 1'b1;
               ra[i]   = 16'($urandom);
               rw[i]   = $urandom;
               rwr[i]  = 1'($urandom_range(1));
            end else if (pend[i] && $urandom_range(60) == 0) begin
               pend[i] = 1'b0;
            end
            req[i] = pend[i];
            set_req(i, rwr[i], ra[i], rw[i]);
         end
         enable  = ($urandom_range(9) != 0);
         reset_n = ($urandom_range(199) != 0);
         if (stall > 0) begin
            pready = 1'b0;
            stall--;
         end else begin
            if ($urandom_range(29) == 0) stall = $urandom_range(22, 12);
            pready = ($urandom_range(2) != 0);
         end
         pslverr = ($urandom_range(7) == 0);
         prdata  = $urandom;
         #2;

         fin    = reset_n && enable && m_act && (m_ph >= 2) && (pready || (m_ph - 2) == TIMEOUT);
         e_done = '0;
         if (fin) e_done[m_own] = 1'b1;
         chk("rnd psel",    64'(psel),    64'(m_act));
         chk("rnd penable", 64'(penable), 64'(m_act && m_ph >= 2));
         chk("rnd done",    64'(done),    64'(e_done));
         if (fin) begin
            chk("rnd rsp_err",   64'(rsp_err),   64'(pready ? pslverr : 1'b1));
            chk("rnd rsp_rdata", 64'(rsp_rdata), 64'(pready ? prdata : 32'h0));
         end
         if (m_act) begin
            chk("rnd paddr",  64'(paddr),  64'(m_addr));
            chk("rnd pwrite", 64'(pwrite), 64'(m_wr));
            chk("rnd pwdata", 64'(pwdata), 64'(m_wd));
         end
         for (int i = 0; i < NREQ; i++) if (e_done[i]) pend[i] = 1'b0;

         if (!reset_n) begin
            m_act = 1'b0;
            m_ptr = 0;
         end else if (enable) begin
            if (!m_act) begin
               for (int k = 0; k < NREQ; k++) begin
                  int idx;
                  idx = (m_ptr + k) % NREQ;
                  if (!m_act && req[idx]) begin
                     m_act  = 1'b1;
                     m_own  = idx;
                     m_ph   = 1;
                     m_addr = ra[idx];
                     m_wd   = rw[idx];
                     m_wr   = rwr[idx];
                  end
               end
               if (m_act) m_ptr = (m_own + 1) % NREQ;
            end else if (fin) begin
               m_act = 1'b0;
            end else begin
               m_ph++;
            end
         end
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
